// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared types and constants for the restoring divider: the
//            sequencer state encoding and the default operand width.
// Ports    : none (package)
// Options  : DIV_ZERO_DETECT_EN (consumed by div_sequencer and divider)
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int C_DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIVIDING = 2'd1,
        ST_STOPPED  = 2'd2
    } state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Purpose  : Control for the restoring divider. Owns the state machine and
//            the iteration counter; emits load / iterate / finish strobes to
//            the datapath and the busy / ready status flags.
// Ports    : clock, reset          - clock and synchronous active-high reset
//            start                 - division request (level-sampled)
//            divisor_zero          - divisor==0 at start (DIV_ZERO_DETECT_EN)
//            load                  - accepted start, capture operands
//            load_zero             - accepted start with zero divisor
//                                    (DIV_ZERO_DETECT_EN)
//            iterate               - perform one shift/subtract step
//            finish                - last step, capture the result
//            busy, ready           - status flags
// Options  : DIV_ZERO_DETECT_EN - short-circuit a zero divisor to stopped
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer
    import div_pkg::*;
#(
    parameter int N = C_DEFAULT_WIDTH
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
`ifdef DIV_ZERO_DETECT_EN
    input  logic divisor_zero,
    output logic load_zero,
`endif
    output logic load,
    output logic iterate,
    output logic finish,
    output logic busy,
    output logic ready
);

    localparam int            CW           = $clog2(N);
    localparam logic [CW-1:0] C_COUNT_INIT = CW'(N - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [CW-1:0] r_count;
    logic          w_accept;

    // A new request is only honoured outside of an iteration.
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_STOPPED));

    // State and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (load) begin
                r_count <= C_COUNT_INIT;
            end else if (iterate && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_STOPPED: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    w_next_state = divisor_zero ? ST_STOPPED : ST_DIVIDING;
`else
                    w_next_state = ST_DIVIDING;
`endif
                end
            end
            ST_DIVIDING: begin
                if (r_count == '0) begin
                    w_next_state = ST_STOPPED;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy    = (r_state == ST_DIVIDING);
        ready   = (r_state == ST_STOPPED);
        iterate = busy;
        finish  = busy && (r_count == '0);
`ifdef DIV_ZERO_DETECT_EN
        load      = w_accept && !divisor_zero;
        load_zero = w_accept && divisor_zero;
`else
        load      = w_accept;
`endif
    end

endmodule : div_sequencer
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
// Module   : divider
// Purpose  : n-bit unsigned restoring divider, one quotient bit per clock.
//            Result is available n+1 cycles after start is accepted and held
//            until the next accepted start.
// Ports    : clock, reset          - clock and synchronous active-high reset
//            start                 - division request (level-sampled)
//            dividend, divisor     - operands, captured on accepted start
//            quotient, remainder   - registered result
//            busy                  - iteration in progress
//            ready                 - valid result held
//            div_by_zero           - zero-divisor flag (DIV_ZERO_DETECT_EN)
// Options  : DIV_ZERO_DETECT_EN - zero divisor skips the iteration and
//                                 raises div_by_zero
// Revision : 1.0 - initial release
// ============================================================================
module divider
    import div_pkg::*;
#(
    parameter int n = C_DEFAULT_WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] dividend,
    input  logic [n-1:0] divisor,
    output logic [n-1:0] quotient,
    output logic [n-1:0] remainder,
    output logic         busy,
`ifdef DIV_ZERO_DETECT_EN
    output logic         div_by_zero,
`endif
    output logic         ready
);

    logic [n:0]   r_a;
    logic [n-1:0] r_q;
    logic [n-1:0] r_m;
    logic [n-1:0] r_quotient;
    logic [n-1:0] r_remainder;

    logic         w_load;
    logic         w_iterate;
    logic         w_finish;
    logic [n:0]   w_a_shift;
    logic [n:0]   w_trial;
    logic [n:0]   w_a_next;
    logic [n-1:0] w_q_next;
    logic         w_trial_ok;

`ifdef DIV_ZERO_DETECT_EN
    logic         w_load_zero;
    logic         r_div_by_zero;

    assign div_by_zero = r_div_by_zero;
`endif

    div_sequencer #(
        .N (n)
    ) u_sequencer (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
`ifdef DIV_ZERO_DETECT_EN
        .divisor_zero (divisor == '0),
        .load_zero    (w_load_zero),
`endif
        .load         (w_load),
        .iterate      (w_iterate),
        .finish       (w_finish),
        .busy         (busy),
        .ready        (ready)
    );

    // One restoring step: shift {A,Q} left, trial-subtract M from A.
    always_comb begin
        w_a_shift  = {r_a[n-1:0], r_q[n-1]};
        w_trial    = w_a_shift - {1'b0, r_m};
        // The bit shifted out of A weighs 2^(n+1), above any divisor, so it
        // would force a successful subtraction (A stays below M, so it is
        // zero in practice).
        w_trial_ok = r_a[n] | ~w_trial[n];
        w_a_next   = w_trial_ok ? w_trial : w_a_shift;
        w_q_next   = {r_q[n-2:0], w_trial_ok};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_a           <= '0;
            r_q           <= '0;
            r_m           <= '0;
            r_quotient    <= '0;
            r_remainder   <= '0;
`ifdef DIV_ZERO_DETECT_EN
            r_div_by_zero <= 1'b0;
`endif
        end else if (w_load) begin
            r_a           <= '0;
            r_q           <= dividend;
            r_m           <= divisor;
`ifdef DIV_ZERO_DETECT_EN
            r_div_by_zero <= 1'b0;
`endif
`ifdef DIV_ZERO_DETECT_EN
        end else if (w_load_zero) begin
            r_a           <= '0;
            r_q           <= dividend;
            r_m           <= divisor;
            r_quotient    <= '1;
            r_remainder   <= dividend;
            r_div_by_zero <= 1'b1;
`endif
        end else if (w_iterate) begin
            r_a <= w_a_next;
            r_q <= w_q_next;
            if (w_finish) begin
                r_quotient  <= w_q_next;
                r_remainder <= w_a_next[n-1:0];
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;

endmodule : divider
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider
// Purpose  : Directed self-checking bench for divider (n=4). Builds with or
//            without DIV_ZERO_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider;

    logic       clock;
    logic       reset;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       busy;
    logic       ready;
`ifdef DIV_ZERO_DETECT_EN
    logic       div_by_zero;
`endif

    int n_checks = 0;
    int n_errors = 0;

    divider #(
        .n (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
`ifdef DIV_ZERO_DETECT_EN
        .div_by_zero (div_by_zero),
`endif
        .ready       (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; sampling point is 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present operands with start for exactly one edge. Returns in cycle 1.
    task automatic pulse_start(input logic [3:0] a, input logic [3:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({quotient, remainder, busy, ready} !== 10'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b ready=%b, want all 0",
                     quotient, remainder, busy, ready);
        end
`ifdef DIV_ZERO_DETECT_EN
        n_checks++;
        if (div_by_zero !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_dbz: got %b want 0", div_by_zero);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        pulse_start(4'd13, 4'd3);
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (busy !== (k <= 4) || ready !== (k == 5)) begin
                n_errors++;
                $display("FAIL basic_timing cycle %0d: got busy=%b ready=%b, want busy=%b ready=%b",
                         k, busy, ready, (k <= 4), (k == 5));
            end
            if (k < 5) step();
        end
        n_checks++;
        if (quotient !== 4'd4 || remainder !== 4'd1) begin
            n_errors++;
            $display("FAIL basic_13_3: got q=%0d r=%0d want q=4 r=1", quotient, remainder);
        end
    endtask

    task automatic test_patterns();
        logic [3:0] a_v [2];
        logic [3:0] b_v [2];
        logic [3:0] q_v [2];
        logic [3:0] r_v [2];
        a_v = '{4'd7, 4'd15};  b_v = '{4'd9, 4'd1};
        q_v = '{4'd0, 4'd15};  r_v = '{4'd7, 4'd0};
        for (int i = 0; i < 2; i++) begin
            pulse_start(a_v[i], b_v[i]);
            step(); step();
            step();
            n_checks++;
            if (ready !== 1'b0) begin
                n_errors++;
                $display("FAIL pattern%0d_early: ready=%b at cycle 4, want 0", i, ready);
            end
            step();
            n_checks++;
            if (ready !== 1'b1 || quotient !== q_v[i] || remainder !== r_v[i]) begin
                n_errors++;
                $display("FAIL pattern%0d_result: got ready=%b q=%0d r=%0d want ready=1 q=%0d r=%0d",
                         i, ready, quotient, remainder, q_v[i], r_v[i]);
            end
        end
    endtask

    task automatic test_restart();
        dividend = 4'd10;
        divisor  = 4'd4;
        start    = 1'b1;
        step();                     // cycle 1 of first run
        repeat (4) step();          // cycle 5
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2) begin
            n_errors++;
            $display("FAIL restart_first: got ready=%b q=%0d r=%0d want ready=1 q=2 r=2",
                     ready, quotient, remainder);
        end
        step();                     // held start restarts: cycle 1 of second run
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0 || quotient !== 4'd2) begin
            n_errors++;
            $display("FAIL restart_again: got busy=%b ready=%b q=%0d want busy=1 ready=0 q=2",
                     busy, ready, quotient);
        end
        start = 1'b0;
        step();                     // cycle 2: stray start with other operands
        start    = 1'b1;
        dividend = 4'd6;
        divisor  = 4'd2;
        step();                     // cycle 3
        start    = 1'b0;
        dividend = 4'd10;
        divisor  = 4'd4;
        step();                     // cycle 4
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_ignore_timing: got busy=%b ready=%b want busy=1 ready=0", busy, ready);
        end
        step();                     // cycle 5
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2) begin
            n_errors++;
            $display("FAIL restart_ignore_result: got ready=%b q=%0d r=%0d want ready=1 q=2 r=2",
                     ready, quotient, remainder);
        end
        step();
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd2 || remainder !== 4'd2) begin
            n_errors++;
            $display("FAIL result_hold: got ready=%b q=%0d r=%0d want ready=1 q=2 r=2",
                     ready, quotient, remainder);
        end
    endtask

    task automatic test_reset_abort();
        pulse_start(4'd13, 4'd3);
        step();                     // cycle 2
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if ({quotient, remainder, busy, ready} !== 10'd0) begin
            n_errors++;
            $display("FAIL abort_outputs: got q=%0d r=%0d busy=%b ready=%b want all 0",
                     quotient, remainder, busy, ready);
        end
        repeat (5) step();
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || quotient !== 4'd0) begin
            n_errors++;
            $display("FAIL abort_no_result: got busy=%b ready=%b q=%0d want 0 0 0", busy, ready, quotient);
        end
        pulse_start(4'd9, 4'd2);
        repeat (4) step();
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
            n_errors++;
            $display("FAIL after_abort_9_2: got ready=%b q=%0d r=%0d want ready=1 q=4 r=1",
                     ready, quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        pulse_start(4'd9, 4'd0);
`ifdef DIV_ZERO_DETECT_EN
        n_checks++;
        if (ready !== 1'b1 || busy !== 1'b0 || quotient !== 4'd15 || remainder !== 4'd9
            || div_by_zero !== 1'b1) begin
            n_errors++;
            $display("FAIL divzero_detect: got ready=%b busy=%b q=%0d r=%0d dbz=%b want 1 0 15 9 1",
                     ready, busy, quotient, remainder, div_by_zero);
        end
        pulse_start(4'd13, 4'd3);
        n_checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL divzero_clear: got dbz=%b busy=%b want dbz=0 busy=1", div_by_zero, busy);
        end
        repeat (4) step();
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd4 || remainder !== 4'd1) begin
            n_errors++;
            $display("FAIL divzero_next: got ready=%b q=%0d r=%0d want 1 4 1", ready, quotient, remainder);
        end
`else
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            n_errors++;
            $display("FAIL divzero_iterate: got busy=%b ready=%b want busy=1 ready=0", busy, ready);
        end
        repeat (4) step();
        n_checks++;
        if (ready !== 1'b1 || quotient !== 4'd15 || remainder !== 4'd9) begin
            n_errors++;
            $display("FAIL divzero_result: got ready=%b q=%0d r=%0d want 1 15 9", ready, quotient, remainder);
        end
`endif
    endtask

    task automatic test_sweep();
        int waited;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                pulse_start(4'(a), 4'(b));
                waited = 0;
                while (ready !== 1'b1 && waited < 10) begin
                    step();
                    waited++;
                end
                n_checks++;
                if (ready !== 1'b1 || waited != 4
                    || (int'(quotient) * b + int'(remainder)) != a
                    || int'(remainder) >= b) begin
                    n_errors++;
                    $display("FAIL sweep %0d/%0d: got q=%0d r=%0d ready=%b after %0d cycles, want q=%0d r=%0d after 4",
                             a, b, quotient, remainder, ready, waited, a / b, a % b);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        #1;
        test_reset();
        test_basic();
        test_patterns();
        test_restart();
        test_reset_abort();
        test_div_zero();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_divider
`default_nettype wire
